// File: rtl/start_sequencer_if.sv
// Purpose: bundles the start-sequencer control inputs, the frame-ROM lookup
//          and the display/status outputs into one port.
// Signals: STARTen, PAUSE, SKIP   control levels / pulse into the sequencer
//          PixROM                 frame data returned for FrameAddr
//          FrameAddr              current frame index
//          PixSTART               registered display pixels
//          RUNen, Busy, Done      status outputs
// Modports: master = controller/ROM side, slave = sequencer.
interface start_sequencer_if #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned N_FRAMES = 6
);
  localparam int unsigned AW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  logic                       STARTen;
  logic                       PAUSE;
  logic                       SKIP;
  logic [ROWS-1:0][COLS-1:0]  PixROM;
  logic [AW-1:0]              FrameAddr;
  logic [ROWS-1:0][COLS-1:0]  PixSTART;
  logic                       RUNen;
  logic                       Busy;
  logic                       Done;

  modport master (
    output STARTen, PAUSE, SKIP, PixROM,
    input  FrameAddr, PixSTART, RUNen, Busy, Done
  );

  modport slave (
    input  STARTen, PAUSE, SKIP, PixROM,
    output FrameAddr, PixSTART, RUNen, Busy, Done
  );
endinterface

// File: rtl/start_sequencer.sv
// Purpose: plays an N_FRAMES start animation at TICK_CYCLES per frame, holds
//          the last frame for RUN_DELAY frame periods, then raises RUNen.
//          LOOP_MODE=1 turns it into an endless attract loop.
// Ports:   CLK          system clock, rising edge
//          RST          asynchronous active-low reset
//          bus (slave)  STARTen/PAUSE/SKIP/PixROM in,
//                       FrameAddr/PixSTART/RUNen/Busy/Done out (all registered)
module start_sequencer #(
  parameter int unsigned ROWS        = 16,
  parameter int unsigned COLS        = 16,
  parameter int unsigned N_FRAMES    = 6,
  parameter int unsigned TICK_CYCLES = 66_666_667,
  parameter int unsigned RUN_DELAY   = 1,
  parameter bit          LOOP_MODE   = 1'b0
) (
  input logic              CLK,
  input logic              RST,
  start_sequencer_if.slave bus
);
  localparam int unsigned AW       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int unsigned TW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DW       = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;
  localparam int unsigned DLY_LAST = (RUN_DELAY > 0) ? RUN_DELAY - 1 : 0;

  localparam logic [AW-1:0] ADDR_LAST = AW'(N_FRAMES - 1);
  localparam logic [AW-1:0] ADDR_PRE  = AW'(N_FRAMES - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DLY_END   = DW'(DLY_LAST);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, RUN} state_e;

  state_e                    state_q, state_d;
  logic [TW-1:0]             tick_q, tick_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [DW-1:0]             dly_q, dly_d;
  logic [ROWS-1:0][COLS-1:0] pix_q;
  logic                      run_q, busy_q, done_q;
  logic                      tick_last_c;

  assign tick_last_c = (tick_q == TICK_LAST);

  // Next-state: STARTen low beats SKIP, which beats PAUSE, which beats the tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    addr_d  = addr_q;
    dly_d   = dly_q;
    if (!bus.STARTen) begin
      state_d = IDLE;
      tick_d  = '0;
      addr_d  = '0;
      dly_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PLAY;
          tick_d  = '0;
          addr_d  = '0;
          dly_d   = '0;
        end
        PLAY, HOLD: begin
          if (bus.SKIP && !LOOP_MODE) begin
            state_d = RUN;
            addr_d  = ADDR_LAST;
            tick_d  = '0;
            dly_d   = '0;
          end else if (!bus.PAUSE) begin
            if (!tick_last_c) begin
              tick_d = tick_q + TW'(1);
            end else begin
              tick_d = '0;
              if (state_q == PLAY) begin
                if (LOOP_MODE) begin
                  addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
                end else begin
                  addr_d = addr_q + AW'(1);
                  // Stepping into the last frame either holds or, with no delay, runs.
                  if (addr_q == ADDR_PRE) state_d = (RUN_DELAY == 0) ? RUN : HOLD;
                end
              end else begin
                // HOLD counts whole frame periods of the delay.
                if (dly_q == DLY_END) begin
                  state_d = RUN;
                  dly_d   = '0;
                end else begin
                  dly_d = dly_q + DW'(1);
                end
              end
            end
          end
        end
        default: ;  // RUN waits for STARTen to drop
      endcase
    end
  end

  // State and registered outputs; outputs follow the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tick_q  <= '0;
      addr_q  <= '0;
      dly_q   <= '0;
      pix_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      addr_q  <= addr_d;
      dly_q   <= dly_d;
      pix_q   <= (state_d == IDLE) ? '0 : bus.PixROM;
      run_q   <= (state_d == RUN);
      busy_q  <= (state_d == PLAY) || (state_d == HOLD);
      done_q  <= (state_d == RUN) && (state_q != RUN);
    end
  end

  assign bus.FrameAddr = addr_q;
  assign bus.PixSTART  = pix_q;
  assign bus.RUNen     = run_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_start_sequencer.sv
// Purpose: self-checking bench for start_sequencer. Two instances share the
//          stimulus: dut0 in normal mode, dut1 in attract (LOOP_MODE=1) mode.
//          A reference model tracks elapsed unpaused cycles and derives frame,
//          run and pixel expectations arithmetically.
module tb_start_sequencer;
  localparam int NF = 6;
  localparam int TC = 2;
  localparam int RD = 1;
  localparam int RW = 4;
  localparam int CW = 8;
  localparam int RUN_AT = (NF - 1 + RD) * TC;

  typedef struct {
    bit          active;
    int          p;       // unpaused cycles since entering PLAY
    bit          skip;
    bit          run;
    bit          done;
    bit          busy;
    int          frame;
    logic [31:0] pix;
  } m_t;

  typedef struct {
    bit st, pa, sk;
    int addr;
    bit run, busy, done;
  } vec_t;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0, pa = 1'b0, sk = 1'b0;
  logic [31:0] rom_tab [8];
  int          total = 0;
  int          bad = 0;
  m_t          m0, m1;

  start_sequencer_if #(.ROWS(RW), .COLS(CW), .N_FRAMES(NF)) bus0 ();
  start_sequencer_if #(.ROWS(RW), .COLS(CW), .N_FRAMES(NF)) bus1 ();

  start_sequencer #(.ROWS(RW), .COLS(CW), .N_FRAMES(NF), .TICK_CYCLES(TC),
                    .RUN_DELAY(RD), .LOOP_MODE(1'b0))
    dut0 (.CLK(CLK), .RST(rst), .bus(bus0.slave));
  start_sequencer #(.ROWS(RW), .COLS(CW), .N_FRAMES(NF), .TICK_CYCLES(TC),
                    .RUN_DELAY(RD), .LOOP_MODE(1'b1))
    dut1 (.CLK(CLK), .RST(rst), .bus(bus1.slave));

  always #5 CLK = ~CLK;

  assign bus0.STARTen = st;
  assign bus0.PAUSE   = pa;
  assign bus0.SKIP    = sk;
  assign bus1.STARTen = st;
  assign bus1.PAUSE   = pa;
  assign bus1.SKIP    = sk;
  assign bus0.PixROM  = rom_tab[bus0.FrameAddr];
  assign bus1.PixROM  = rom_tab[bus1.FrameAddr];

  function automatic m_t mreset();
    m_t r;
    r.active = 1'b0; r.p = 0; r.skip = 1'b0; r.run = 1'b0;
    r.done = 1'b0; r.busy = 1'b0; r.frame = 0; r.pix = '0;
    return r;
  endfunction

  // One clock edge of the behavioural model.
  function automatic m_t mstep(input m_t m, input bit loop,
                               input bit st_i, input bit pa_i, input bit sk_i);
    m_t n;
    n = m;
    if (!st_i) begin
      n.active = 1'b0; n.p = 0; n.skip = 1'b0;
    end else if (!m.active) begin
      n.active = 1'b1; n.p = 0; n.skip = 1'b0;
    end else if (m.run) begin
      n.p = m.p;
    end else if (sk_i && !loop) begin
      n.skip = 1'b1;
    end else if (!pa_i) begin
      n.p = m.p + 1;
    end
    n.run   = n.active && !loop && (n.skip || n.p >= RUN_AT);
    if (!n.active)  n.frame = 0;
    else if (loop)  n.frame = (n.p / TC) % NF;
    else if (n.run) n.frame = NF - 1;
    else            n.frame = (n.p / TC < NF - 1) ? n.p / TC : NF - 1;
    n.done  = n.run && !m.run;
    n.busy  = n.active && !n.run;
    n.pix   = n.active ? rom_tab[m.frame] : '0;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("m0_addr", 32'(bus0.FrameAddr), 32'(m0.frame));
    chk("m0_pix",  32'(bus0.PixSTART),  m0.pix);
    chk("m0_run",  32'(bus0.RUNen),     32'(m0.run));
    chk("m0_busy", 32'(bus0.Busy),      32'(m0.busy));
    chk("m0_done", 32'(bus0.Done),      32'(m0.done));
    chk("m1_addr", 32'(bus1.FrameAddr), 32'(m1.frame));
    chk("m1_pix",  32'(bus1.PixSTART),  m1.pix);
    chk("m1_run",  32'(bus1.RUNen),     32'(m1.run));
    chk("m1_busy", 32'(bus1.Busy),      32'(m1.busy));
    chk("m1_done", 32'(bus1.Done),      32'(m1.done));
  endtask

  task automatic step();
    @(posedge CLK);
    if (!rst) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 1'b0, st, pa, sk);
      m1 = mstep(m1, 1'b1, st, pa, sk);
    end
    #1;
    check_models();
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] prev;
    int          f2;

    for (int i = 0; i < 8; i++) rom_tab[i] = $urandom;
    m0 = mreset();
    m1 = mreset();

    // Async reset at time zero, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_addr", 32'(bus0.FrameAddr), 32'd0);
    chk("rst_pix",  32'(bus0.PixSTART),  32'd0);
    chk("rst_run",  32'(bus0.RUNen),     32'd0);
    chk("rst_busy", 32'(bus0.Busy),      32'd0);
    chk("rst_done", 32'(bus0.Done),      32'd0);
    step();
    rst = 1'b1;
    // Stays idle after reset while STARTen is low.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", 32'(bus0.Busy), 32'd0);
    end

    // Full sequence, STARTen held, then dropped.
    tbl.push_back('{1,0,0, 0,0,1,0});  // E0
    tbl.push_back('{1,0,0, 0,0,1,0});
    tbl.push_back('{1,0,0, 1,0,1,0});
    tbl.push_back('{1,0,0, 1,0,1,0});
    tbl.push_back('{1,0,0, 2,0,1,0});
    tbl.push_back('{1,0,0, 2,0,1,0});
    tbl.push_back('{1,0,0, 3,0,1,0});
    tbl.push_back('{1,0,0, 3,0,1,0});
    tbl.push_back('{1,0,0, 4,0,1,0});
    tbl.push_back('{1,0,0, 4,0,1,0});
    tbl.push_back('{1,0,0, 5,0,1,0});  // E10 HOLD
    tbl.push_back('{1,0,0, 5,0,1,0});
    tbl.push_back('{1,0,0, 5,1,0,1});  // E12 RUN + Done
    tbl.push_back('{1,0,0, 5,1,0,0});
    tbl.push_back('{1,0,0, 5,1,0,0});
    tbl.push_back('{0,0,0, 0,0,0,0});  // back to IDLE
    foreach (tbl[i]) begin
      st = tbl[i].st; pa = tbl[i].pa; sk = tbl[i].sk;
      prev = bus0.PixROM;
      step();
      chk($sformatf("tbl%0d_addr", i), 32'(bus0.FrameAddr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_run", i),  32'(bus0.RUNen),     32'(tbl[i].run));
      chk($sformatf("tbl%0d_busy", i), 32'(bus0.Busy),      32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(bus0.Done),      32'(tbl[i].done));
      chk($sformatf("tbl%0d_pix", i),  32'(bus0.PixSTART),  tbl[i].st ? prev : 32'd0);
    end

    // PAUSE for 5 cycles in frame 2 stretches it to 7 cycles.
    st = 1'b1; pa = 1'b0; sk = 1'b0;
    step();  // E0
    f2 = 0;
    for (int k = 1; k <= 17; k++) begin
      pa = (k >= 5 && k <= 9);
      step();
      if (bus0.FrameAddr == 3'd2) f2++;
      if (k == 16) chk("pause_run_e16", 32'(bus0.RUNen), 32'd0);
      if (k == 17) begin
        chk("pause_run_e17",  32'(bus0.RUNen), 32'd1);
        chk("pause_done_e17", 32'(bus0.Done),  32'd1);
      end
    end
    pa = 1'b0;
    chk("pause_f2_len", 32'(f2), 32'd7);
    st = 1'b0;
    step();

    // SKIP sampled at E0+4 jumps straight to RUN.
    st = 1'b1;
    step();  // E0
    for (int k = 1; k <= 3; k++) step();
    sk = 1'b1;
    step();  // E4
    sk = 1'b0;
    chk("skip_run",   32'(bus0.RUNen),     32'd1);
    chk("skip_done",  32'(bus0.Done),      32'd1);
    chk("skip_addr",  32'(bus0.FrameAddr), 32'd5);
    chk("skip_loop_addr", 32'(bus1.FrameAddr), 32'd2);
    step();
    chk("skip_done_once", 32'(bus0.Done), 32'd0);
    st = 1'b0;
    step();

    // Abort mid-sequence, then restart from frame 0.
    st = 1'b1;
    step();  // E0
    for (int k = 1; k <= 5; k++) step();
    st = 1'b0;
    step();  // E6
    chk("abort_addr", 32'(bus0.FrameAddr), 32'd0);
    chk("abort_run",  32'(bus0.RUNen),     32'd0);
    chk("abort_pix",  32'(bus0.PixSTART),  32'd0);
    chk("abort_busy", 32'(bus0.Busy),      32'd0);
    st = 1'b1;
    step();
    chk("restart_addr0", 32'(bus0.FrameAddr), 32'd0);
    chk("restart_busy",  32'(bus0.Busy),      32'd1);
    step();
    step();
    chk("restart_addr1", 32'(bus0.FrameAddr), 32'd1);
    st = 1'b0;
    step();

    // Attract loop wraps 0..5 and ignores SKIP.
    st = 1'b1;
    step();  // E0
    chk("loop_addr_e0", 32'(bus1.FrameAddr), 32'd0);
    for (int k = 1; k <= 24; k++) begin
      sk = (k == 7);
      step();
      chk($sformatf("loop_addr_e%0d", k), 32'(bus1.FrameAddr), 32'((k / 2) % 6));
      chk("loop_run",  32'(bus1.RUNen), 32'd0);
      chk("loop_done", 32'(bus1.Done),  32'd0);
    end
    sk = 1'b0;

    // dut0 took SKIP above and sits in RUN; reset between edges clears it.
    chk("pre_rst_run", 32'(bus0.RUNen), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_run",  32'(bus0.RUNen),     32'd0);
    chk("async_pix",  32'(bus0.PixSTART),  32'd0);
    chk("async_addr", 32'(bus0.FrameAddr), 32'd0);
    chk("async_done", 32'(bus0.Done),      32'd0);
    m0 = mreset();
    m1 = mreset();
    step();
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 99) > 3);
      pa = ($urandom_range(0, 99) < 20);
      sk = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter ROWS, default 16, display rows.
REQ-002 Parameter COLS, default 16, display columns.
REQ-003 Parameter N_FRAMES, default 6, frames per sequence; frame N_FRAMES-1 is the hold frame; legal range >= 2.
REQ-004 Parameter TICK_CYCLES, default 66_666_667, clock cycles per frame (0.75 Hz at 50 MHz); legal range >= 1.
REQ-005 Parameter RUN_DELAY, default 1, frame periods spent in HOLD before RUNen asserts; legal range >= 0.
REQ-006 Parameter LOOP_MODE, default 0; 1 = attract mode, the sequence wraps forever and never asserts RUNen.
REQ-007 CLK  input  1  system clock; all state changes on its rising edge.
REQ-008 RST  input  1  reset, asynchronous, active-low.
REQ-009 STARTen  input  1  level enable; high runs the sequence, low returns the block to IDLE.
REQ-010 PAUSE  input  1  level; freezes the tick counter and the frame index.
REQ-011 SKIP  input  1  single-cycle pulse; jumps to the end of the sequence.
REQ-012 PixROM  input  [ROWS-1:0][COLS-1:0]  combinational frame data addressed by FrameAddr.
REQ-013 FrameAddr  output  max(1,$clog2(N_FRAMES))  current frame index.
REQ-014 PixSTART  output  [ROWS-1:0][COLS-1:0]  registered display pixels.
REQ-015 RUNen  output  1  game-run enable.
REQ-016 Busy  output  1  high in PLAY or HOLD.
REQ-017 Done  output  1  one-cycle pulse on entry to RUN.

Function
REQ-018 The FSM SHALL have states IDLE, PLAY, HOLD and RUN.
REQ-019 IDLE: FrameAddr=0, tick=0, PixSTART=0, RUNen=0, Busy=0; STARTen=1 at an edge -> PLAY with FrameAddr=0 and tick=0.
REQ-020 PLAY, PAUSE=0: tick==TICK_CYCLES-1 -> tick<=0 and FrameAddr++, otherwise tick++; each frame therefore lasts exactly TICK_CYCLES cycles.
REQ-021 PLAY, LOOP_MODE=0: the increment into frame N_FRAMES-1 -> HOLD with tick=0; RUN_DELAY=0 -> RUN directly.
REQ-022 PLAY, LOOP_MODE=1: the increment past frame N_FRAMES-1 SHALL wrap FrameAddr to 0 and remain in PLAY; HOLD and RUN are unreachable.
REQ-023 HOLD: FrameAddr=N_FRAMES-1; after RUN_DELAY*TICK_CYCLES unpaused cycles -> RUN.
REQ-024 RUN: RUNen=1, FrameAddr=N_FRAMES-1, Busy=0; the block stays in RUN until STARTen=0.
REQ-025 PAUSE=1 in PLAY or HOLD SHALL hold tick, FrameAddr and state unchanged; PAUSE SHALL have no effect in IDLE or RUN.
REQ-026 SKIP=1 in PLAY or HOLD with LOOP_MODE=0 -> RUN at the next edge with FrameAddr=N_FRAMES-1.
REQ-027 SKIP SHALL be ignored in IDLE, in RUN, and whenever LOOP_MODE=1.
REQ-028 Priority, highest first: STARTen=0, then SKIP, then PAUSE, then the tick advance.
REQ-029 STARTen=0 in any state -> IDLE at the next edge, clearing RUNen, tick and FrameAddr; mid-sequence abort is legal.
REQ-030 PixSTART SHALL be PixROM registered one cycle (one cycle behind FrameAddr) in PLAY, HOLD and RUN, and forced to 0 on the edge that enters IDLE.
REQ-031 Done SHALL be high for exactly the first cycle in RUN.
REQ-032 The tick counter SHALL be max(1,$clog2(TICK_CYCLES)) bits wide and SHALL never exceed TICK_CYCLES-1.

Reset
REQ-033 RST=0 SHALL immediately, without waiting for a clock edge, force IDLE, tick=0, FrameAddr=0, PixSTART=0, RUNen=0, Busy=0 and Done=0.
REQ-034 On RST deassertion the block SHALL leave IDLE no earlier than the first rising edge at which STARTen=1.

Verification (TICK_CYCLES=2, N_FRAMES=6, RUN_DELAY=1, LOOP_MODE=0 unless stated; E0 = the edge that enters PLAY)
REQ-035 STARTen held at 1 -> FrameAddr 0,1,2,3,4, each for 2 cycles; FrameAddr=5 and HOLD from E0+10; RUNen=1 and a Done pulse at E0+12; PixSTART equals PixROM of the previous cycle throughout.
REQ-036 PAUSE=1 for 5 cycles while in frame 2 -> frame 2 lasts 7 cycles and RUNen asserts at E0+17.
REQ-037 SKIP pulse at E0+3 -> RUNen=1, Done pulse and FrameAddr=5 at E0+4.
REQ-038 STARTen dropped at E0+5 -> IDLE at E0+6 with FrameAddr=0, RUNen=0 and PixSTART=0; re-raising STARTen restarts from frame 0.
REQ-039 LOOP_MODE=1 -> FrameAddr sequence 0..5,0..5 repeating, 2 cycles per frame; RUNen and Done stay 0 and SKIP is ignored.
REQ-040 RST pulled low between clock edges while in RUN -> RUNen=0 and PixSTART=0 before the next edge.
